// File: rtl/scan_ctrl.sv
// Command sequencer for the scan-chain engine: gates the DUT clock, launches scans,
// watches engine activity with a timeout and returns one status per command.
module scan_ctrl #(
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int LEVEL_W        = 10
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [15:0]        cmd_length,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic               dut_ck_enable,
  output logic               halted,
  output logic               scan_start,
  output logic [15:0]        scan_length,
  input  logic               scan_busy,
  output logic               scan_abort_n,
  input  logic [LEVEL_W-1:0] in_fifo_level
);

  typedef enum logic [2:0] {
    IDLE, HALT_WAIT, SCAN_ARM, SCAN_RUN, ABORT, RESP
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_HALT   = 2'b01;
  localparam logic [1:0] OP_SCAN   = 2'b10;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [1:0] ST_BAD_STATE = 2'b10;
  localparam logic [1:0] ST_BAD_ARG   = 2'b11;
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [19:0] tcnt;
  logic [16:0] words;
  logic        fifo_short;

  // 17-bit sum so a 65535-bit request does not wrap before the shift
  assign words      = (17'(cmd_length) + 17'd31) >> 5;
  assign fifo_short = 32'(in_fifo_level) < 32'(words);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= ST_OK;
      dut_ck_enable <= 1'b1;
      halted        <= 1'b0;
      scan_start    <= 1'b0;
      scan_length   <= '0;
      scan_abort_n  <= 1'b1;
    end else begin
      scan_start <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_NOP: begin
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                state      <= RESP;
              end
              OP_HALT: begin
                if (halted) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_OK;
                  state      <= RESP;
                end else begin
                  dut_ck_enable <= 1'b0;
                  cnt           <= 8'(HALT_CYCLES);
                  state         <= HALT_WAIT;
                end
              end
              OP_SCAN: begin
                if (!halted) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_BAD_STATE;
                  state      <= RESP;
                end else if (cmd_length == 16'd0 || fifo_short) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_BAD_ARG;
                  state      <= RESP;
                end else begin
                  scan_length <= cmd_length;
                  scan_start  <= 1'b1;
                  tcnt        <= '0;
                  state       <= SCAN_ARM;
                end
              end
              default: begin
                rsp_valid <= 1'b1;
                state     <= RESP;
                if (halted) begin
                  dut_ck_enable <= 1'b1;
                  halted        <= 1'b0;
                  rsp_status    <= ST_OK;
                end else begin
                  rsp_status <= ST_BAD_STATE;
                end
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        HALT_WAIT: begin
          if (cnt == 8'd0) begin
            halted     <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            state      <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SCAN_ARM, SCAN_RUN: begin
          tcnt <= tcnt + 20'd1;
          // completion wins over timeout when both happen on the same edge
          if (state == SCAN_RUN && !scan_busy) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            state      <= RESP;
          end else if (tcnt >= TMO_LAST) begin
            scan_abort_n <= 1'b0;
            cnt          <= 8'd1;
            state        <= ABORT;
          end else if (scan_busy) begin
            state <= SCAN_RUN;
          end
        end
        ABORT: begin
          if (cnt == 8'd0) begin
            scan_abort_n <= 1'b1;
            rsp_valid    <= 1'b1;
            rsp_status   <= ST_TIMEOUT;
            state        <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: directed vector table, randomized commands
// against a transaction-level model, and hand-written reset/hold sequences.
module tb_scan_ctrl;
  localparam int HC = 4;
  localparam int TC = 160;
  localparam int LW = 10;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [15:0]   cmd_length = 16'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic          dut_ck_enable;
  logic          halted;
  logic          scan_start;
  logic [15:0]   scan_length;
  logic          scan_busy = 1'b0;
  logic          scan_abort_n;
  logic [LW-1:0] in_fifo_level = '0;

  scan_ctrl #(.HALT_CYCLES(HC), .TIMEOUT_CYCLES(TC), .LEVEL_W(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_length(cmd_length),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .dut_ck_enable(dut_ck_enable), .halted(halted),
    .scan_start(scan_start), .scan_length(scan_length), .scan_busy(scan_busy),
    .scan_abort_n(scan_abort_n), .in_fifo_level(in_fifo_level)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int last_len = 0;
  bit m_halted = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference: status and resulting ownership from the command rules
  task automatic model(input bit h, input int op, input int len, input int lvl, input bit stuck,
                       output int st, output bit nh, output int starts);
    nh = h; starts = 0; st = 0;
    case (op)
      0: st = 0;
      1: begin st = 0; nh = 1'b1; end
      2: begin
        if (!h) st = 2;
        else if (len == 0 || lvl * 32 < len) st = 3;
        else begin starts = 1; st = stuck ? 1 : 0; end
      end
      default: begin
        if (!h) st = 2;
        else begin st = 0; nh = 1'b0; end
      end
    endcase
  endtask

  task automatic do_cmd(input int op, input int len, input int lvl, input int bdel, input int blen,
                        input int rdel, output int st, output int starts, output int lat,
                        output int abort_lo);
    int t;
    int since;
    int held;
    starts = 0; abort_lo = 0; lat = 0; since = -1; st = 0; t = 0;
    while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
    check("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_op = 2'(op); cmd_length = 16'(len); in_fifo_level = LW'(lvl); cmd_valid = 1'b1;
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_length = 16'($urandom);
      if (scan_start) begin starts++; since = 0; end
      else if (since >= 0) since++;
      scan_busy = (since >= 0) && (since >= bdel) && (blen < 0 || since < bdel + blen);
      if (!scan_abort_n) abort_lo++;
      if (rsp_valid || lat >= 2000) break;
      @(posedge aclk); lat++;
    end
    if (!rsp_valid) begin
      check("rsp_wait", 0, 1);
      scan_busy = 1'b0;
      return;
    end
    st = int'(rsp_status); held = int'(rsp_status);
    for (int i = 0; i < rdel; i++) begin
      @(negedge aclk);
      check("hold_rsp_valid", int'(rsp_valid), 1);
      check("hold_rsp_status", int'(rsp_status), held);
      check("hold_cmd_ready", int'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0; scan_busy = 1'b0;
    check("rsp_cleared", int'(rsp_valid), 0);
    check("ready_after_rsp", int'(cmd_ready), 1);
  endtask

  task automatic run_check(input string name, input int op, input int len, input int lvl,
                           input int bdel, input int blen, input int rdel,
                           input int exp_st, input bit exp_h, input int exp_starts);
    int st, starts, lat, abort_lo, exp_lat;
    bit was_h;
    was_h = halted;
    do_cmd(op, len, lvl, bdel, blen, rdel, st, starts, lat, abort_lo);
    if (exp_starts != 0) last_len = len;
    $display("[TB] %s op=%0d len=%0d lvl=%0d status=%0d lat=%0d starts=%0d", name, op, len, lvl,
             st, lat, starts);
    check({name, "_status"}, st, exp_st);
    check({name, "_halted"}, int'(halted), int'(exp_h));
    check({name, "_ck_en"}, int'(dut_ck_enable), int'(!exp_h));
    check({name, "_starts"}, starts, exp_starts);
    check({name, "_abort_cycles"}, abort_lo, (exp_st == 1) ? 2 : 0);
    check({name, "_scan_length"}, int'(scan_length), last_len);
    if (op == 1 && !was_h) exp_lat = HC + 1;
    else if (exp_st == 1) exp_lat = TC + 2;
    else if (exp_starts != 0) exp_lat = -1;
    else exp_lat = 0;
    if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
  endtask

  typedef struct {
    int op; int len; int lvl; int bdel; int blen; int rdel;
    int st; bit h; int starts;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int st, starts;
    bit nh, stuck;
    int op, len, lvl, bdel, blen, rdel, t;

    vecs[0]  = '{0,   0, 0, 0,   0, 0, 0, 1'b0, 0};  // NOP
    vecs[1]  = '{2,  64, 2, 0,   0, 0, 2, 1'b0, 0};  // SCAN not halted
    vecs[2]  = '{3,   0, 0, 0,   0, 0, 2, 1'b0, 0};  // RESUME not halted
    vecs[3]  = '{1,   0, 0, 0,   0, 1, 0, 1'b1, 0};  // HALT
    vecs[4]  = '{1,   0, 0, 0,   0, 0, 0, 1'b1, 0};  // HALT idempotent
    vecs[5]  = '{2,   0, 5, 0,   0, 0, 3, 1'b1, 0};  // length 0
    vecs[6]  = '{2,  33, 1, 0,   0, 0, 3, 1'b1, 0};  // 33 bits need 2 words
    vecs[7]  = '{2,  33, 2, 0,   1, 0, 0, 1'b1, 1};  // single-cycle busy
    vecs[8]  = '{2,  64, 2, 2, 130, 10, 0, 1'b1, 1}; // long busy, response held
    vecs[9]  = '{2,  32, 1, 1,  -1, 0, 1, 1'b1, 1};  // busy stuck -> timeout
    vecs[10] = '{3,   0, 0, 0,   0, 0, 0, 1'b0, 0};  // RESUME
    vecs[11] = '{3,   0, 0, 0,   0, 0, 2, 1'b0, 0};  // second RESUME

    #12;
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_status", int'(rsp_status), 0);
    check("rst_ck_en", int'(dut_ck_enable), 1);
    check("rst_halted", int'(halted), 0);
    check("rst_scan_start", int'(scan_start), 0);
    check("rst_scan_length", int'(scan_length), 0);
    check("rst_abort_n", int'(scan_abort_n), 1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_after_reset", int'(cmd_ready), 1);

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].len, vecs[i].lvl, vecs[i].bdel,
                vecs[i].blen, vecs[i].rdel, vecs[i].st, vecs[i].h, vecs[i].starts);
    m_halted = halted;

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      t = int'($urandom_range(0, 9));
      len = (t == 0) ? 0 : (t < 5) ? int'($urandom_range(1, 128)) : int'($urandom_range(1, 700));
      lvl = int'($urandom_range(0, 24));
      stuck = ($urandom_range(0, 7) == 0);
      bdel = int'($urandom_range(0, 4));
      blen = stuck ? -1 : int'($urandom_range(1, 40));
      rdel = int'($urandom_range(0, 3));
      model(m_halted, op, len, lvl, stuck, st, nh, starts);
      run_check($sformatf("rnd%0d", n), op, len, lvl, bdel, blen, rdel, st, nh, starts);
      m_halted = nh;
    end

    if (!m_halted) begin
      run_check("pre_reset_halt", 1, 0, 0, 0, 0, 0, 0, 1'b1, 0);
      m_halted = 1'b1;
    end
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
    cmd_op = 2'b10; cmd_length = 16'd40; in_fifo_level = LW'(2); cmd_valid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0; scan_busy = 1'b1;
    repeat (10) @(negedge aclk);
    check("mid_scan_halted", int'(halted), 1);
    check("mid_scan_no_rsp", int'(rsp_valid), 0);
    #2 aresetn = 1'b0;
    #1;
    $display("[TB] async reset mid-scan ck_en=%0d rsp_valid=%0d", dut_ck_enable, rsp_valid);
    check("arst_ck_en", int'(dut_ck_enable), 1);
    check("arst_rsp_valid", int'(rsp_valid), 0);
    check("arst_halted", int'(halted), 0);
    check("arst_abort_n", int'(scan_abort_n), 1);
    check("arst_scan_length", int'(scan_length), 0);
    scan_busy = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("arst_ready_again", int'(cmd_ready), 1);
    last_len = 0;
    run_check("post_reset_scan", 2, 64, 2, 0, 3, 0, 2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
